// File: rtl/buzzer_melody_player_if.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_melody_player_if
// Description : Control/status bundle between the melody player and the
//               button/LED logic.
//               start    - level request to play the tune (acted on in IDLE)
//               stop     - level abort, wins over everything but reset
//               buzzer   - square wave to the piezo pin
//               busy     - high while a note or inter-note gap is running
//               done     - one-cycle pulse on normal completion
//               note_idx - ROM entry currently playing, 0 when idle
// Revision    : 1.0 - initial release
// ============================================================================
interface buzzer_melody_player_if;
  logic       start;
  logic       stop;
  logic       buzzer;
  logic       busy;
  logic       done;
  logic [2:0] note_idx;

  // Button/LED side drives requests and observes status.
  modport master (
    output start,
    output stop,
    input  buzzer,
    input  busy,
    input  done,
    input  note_idx
  );

  // Player side.
  modport slave (
    input  start,
    input  stop,
    output buzzer,
    output busy,
    output done,
    output note_idx
  );
endinterface
`default_nettype wire

// File: rtl/buzzer_melody_player.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_melody_player
// Description : Replays a fixed 8-note tune on the piezo buzzer. Each ROM
//               entry is (half-period N, beats); a note sounds a square wave
//               of period 2*(N+1) clocks for beats*BEAT_DIV clocks, then the
//               pin is silent for GAP_CYCLES clocks. N = 0 is a rest.
// Ports       : clk_50MHz    - 50 MHz system clock
//               reset_button - synchronous active-high reset
//               bus          - slave side of buzzer_melody_player_if
//                              (start/stop in; buzzer/busy/done/note_idx out)
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_melody_player #(
  parameter int unsigned BEAT_DIV   = 6_250_000,
  parameter int unsigned GAP_CYCLES = 500_000
) (
  input  wire logic             clk_50MHz,
  input  wire logic             reset_button,
  buzzer_melody_player_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [31:0] c_beat_div = 32'(BEAT_DIV);
  localparam logic [31:0] c_gap_last = 32'(GAP_CYCLES) - 32'd1;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_idx;
  logic [15:0] r_tc;      // position inside the current half-period
  logic [31:0] r_cnt;     // cycles spent in the current TONE or GAP
  logic        r_buzzer;
  logic        r_done;

  logic [15:0] w_half;
  logic [2:0]  w_beats;
  logic [31:0] w_note_last;
  logic        w_finish;

  // Melody ROM.
  always_comb begin
    w_half  = 16'd0;
    w_beats = 3'd2;
    unique case (r_idx)
      3'd0: begin w_half = 16'd60000; w_beats = 3'd2; end
      3'd1: begin w_half = 16'd47801; w_beats = 3'd2; end
      3'd2: begin w_half = 16'd42589; w_beats = 3'd2; end
      3'd3: begin w_half = 16'd37935; w_beats = 3'd2; end
      3'd4: begin w_half = 16'd31887; w_beats = 3'd4; end
      3'd5: begin w_half = 16'd0;     w_beats = 3'd2; end
      3'd6: begin w_half = 16'd37935; w_beats = 3'd2; end
      3'd7: begin w_half = 16'd47801; w_beats = 3'd4; end
      default: begin w_half = 16'd0; w_beats = 3'd2; end
    endcase
  end

  assign w_note_last = ({29'd0, w_beats} * c_beat_div) - 32'd1;

  // Next-state logic. stop overrides every transition, including the
  // completion pulse on the last gap cycle.
  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_TONE;
      end
      S_TONE: begin
        if (r_cnt == w_note_last) w_state_next = S_GAP;
      end
      S_GAP: begin
        if (r_cnt == c_gap_last) begin
          if (r_idx == 3'd7) begin
            w_state_next = S_IDLE;
            w_finish     = 1'b1;
          end else begin
            w_state_next = S_TONE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (bus.stop) begin
      w_state_next = S_IDLE;
      w_finish     = 1'b0;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      r_state  <= S_IDLE;
      r_idx    <= 3'd0;
      r_tc     <= 16'd0;
      r_cnt    <= 32'd0;
      r_buzzer <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_finish;
      if (w_state_next != r_state) begin
        // Every state change starts a fresh, silent interval.
        r_cnt    <= 32'd0;
        r_tc     <= 16'd0;
        r_buzzer <= 1'b0;
        if (r_state == S_GAP && w_state_next == S_TONE) begin
          r_idx <= r_idx + 3'd1;
        end else if (w_state_next != S_GAP) begin
          r_idx <= 3'd0;
        end
      end else if (r_state == S_TONE) begin
        r_cnt <= r_cnt + 32'd1;
        if (r_tc == w_half) begin
          r_tc <= 16'd0;
          // A rest keeps the pin low.
          if (w_half != 16'd0) r_buzzer <= ~r_buzzer;
        end else begin
          r_tc <= r_tc + 16'd1;
        end
      end else if (r_state == S_GAP) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign bus.buzzer   = r_buzzer;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.note_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_melody_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_buzzer_melody_player
// Description : Two players share one clock: dut_a (BEAT_DIV=10, GAP=4) gets
//               directed scenarios followed by random start/stop/reset
//               traffic; dut_b (BEAT_DIV=33000, GAP=4) plays long enough to
//               show the first note's square wave and the first gap. Both are
//               compared every cycle against a schedule-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buzzer_melody_player;

  localparam int BD_A = 10;
  localparam int BD_B = 33000;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  bit   b_done = 1'b0;

  int checks = 0;
  int errors = 0;

  buzzer_melody_player_if bus_a ();
  buzzer_melody_player_if bus_b ();

  buzzer_melody_player #(.BEAT_DIV(BD_A), .GAP_CYCLES(GAP)) dut_a (
    .clk_50MHz    (clk),
    .reset_button (rst_a),
    .bus          (bus_a)
  );

  buzzer_melody_player #(.BEAT_DIV(BD_B), .GAP_CYCLES(GAP)) dut_b (
    .clk_50MHz    (clk),
    .reset_button (rst_b),
    .bus          (bus_b)
  );

  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int note_n(input int i);
    case (i)
      0: return 60000; 1: return 47801; 2: return 42589; 3: return 37935;
      4: return 31887; 5: return 0;     6: return 37935; default: return 47801;
    endcase
  endfunction

  function automatic int note_b(input int i);
    return (i == 4 || i == 7) ? 4 : 2;
  endfunction

  // {note_idx, buzzer} at cycle t of a playback (t = 0 is first busy cycle).
  function automatic logic [3:0] sched(input int t, input int bd);
    int s;
    int len;
    int n;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      len = note_b(i) * bd;
      n   = note_n(i);
      if (t >= s && t < s + len)
        return {3'(i), (n != 0) && ((((t - s) / (n + 1)) % 2) == 1)};
      if (t >= s + len && t < s + len + GAP)
        return {3'(i), 1'b0};
      s = s + len + GAP;
    end
    return 4'd0;
  endfunction

  bit m_valid [2];
  bit m_play  [2];
  bit m_done  [2];
  int m_t     [2];

  task automatic model_step(input int k, input logic rst, input logic start, input logic stop);
    int total;
    total = 20 * (k == 0 ? BD_A : BD_B) + 8 * GAP;
    if (rst) begin
      m_valid[k] = 1'b1;
      m_play[k]  = 1'b0;
      m_done[k]  = 1'b0;
    end else if (stop) begin
      m_play[k] = 1'b0;
      m_done[k] = 1'b0;
    end else if (m_play[k]) begin
      if (m_t[k] == total - 1) begin
        m_play[k] = 1'b0;
        m_done[k] = 1'b1;
      end else begin
        m_t[k]    = m_t[k] + 1;
        m_done[k] = 1'b0;
      end
    end else begin
      m_done[k] = 1'b0;
      if (start) begin
        m_play[k] = 1'b1;
        m_t[k]    = 0;
      end
    end
  endtask

  // Packed as {busy, done, note_idx[2:0], buzzer}.
  function automatic logic [5:0] model_outs(input int k);
    if (!m_play[k]) return {1'b0, m_done[k], 4'd0};
    return {1'b1, 1'b0, sched(m_t[k], k == 0 ? BD_A : BD_B)};
  endfunction

  always @(posedge clk) begin
    model_step(0, rst_a, bus_a.start, bus_a.stop);
    model_step(1, rst_b, bus_b.start, bus_b.stop);
  end

  function automatic logic [5:0] outs_a();
    return {bus_a.busy, bus_a.done, bus_a.note_idx, bus_a.buzzer};
  endfunction

  function automatic logic [5:0] outs_b();
    return {bus_b.busy, bus_b.done, bus_b.note_idx, bus_b.buzzer};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b (busy,done,idx,buzzer)", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid[0]) check("model_a", outs_a(), model_outs(0));
    if (m_valid[1]) check("model_b", outs_b(), model_outs(1));
  end

  // ---------------- dut_a helpers ----------------
  // Counts busy cycles from the current one; returns on the first idle cycle.
  task automatic busy_len(input bit repulse, output int len, output int steps, output bit tone_seen);
    logic [2:0] prev;
    len = 0; steps = 0; tone_seen = 1'b0;
    prev = bus_a.note_idx;
    while (bus_a.busy && len < 1000) begin
      if (bus_a.note_idx == prev + 3'd1) steps++;
      prev = bus_a.note_idx;
      if (bus_a.buzzer) tone_seen = 1'b1;
      if (repulse) bus_a.start = (bus_a.note_idx == 3'd2);
      len++;
      @(negedge clk);
    end
    if (repulse) bus_a.start = 1'b0;
  endtask

  task automatic wait_idx(input logic [2:0] target, input string name);
    int n;
    n = 0;
    while (bus_a.note_idx != target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, {3'd0, bus_a.note_idx}, {3'd0, target});
  endtask

  task automatic run_a();
    int  len;
    int  steps;
    bit  tone_seen;
    int  r;
    bit  hold;
    int  cyc;
    rst_a = 1'b1; bus_a.start = 1'b1; bus_a.stop = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_hold", outs_a(), 6'b000000);
    end
    rst_a = 1'b0;
    @(negedge clk);
    check("start_after_reset", outs_a(), 6'b100000);
    bus_a.start = 1'b0;
    busy_len(1'b0, len, steps, tone_seen);
    check("tune_length", 6'(len - 200), 6'd32);
    check("idx_steps", 6'(steps), 6'd7);
    check("short_beats_silent", {5'd0, tone_seen}, 6'd0);
    check("done_on_fall", outs_a(), 6'b010000);
    @(negedge clk);
    check("done_one_cycle", outs_a(), 6'b000000);

    // start and stop together in IDLE
    bus_a.start = 1'b1; bus_a.stop = 1'b1;
    @(negedge clk);
    check("start_stop_idle", outs_a(), 6'b000000);
    bus_a.stop = 1'b0;

    // stop during note 3 (start still high for this cycle's edge)
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_idx(3'd3, "reach_note3");
    bus_a.stop = 1'b1;
    @(negedge clk);
    check("stop_note3", outs_a(), 6'b000000);
    bus_a.stop = 1'b0;
    @(negedge clk);
    check("stop_no_done", outs_a(), 6'b000000);

    // re-pulse start during note 2
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    busy_len(1'b1, len, steps, tone_seen);
    check("restart_ignored_len", 6'(len - 200), 6'd32);
    @(negedge clk);

    // reset in the gap after note 7
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_idx(3'd7, "reach_note7");
    repeat (41) @(negedge clk);
    check("in_gap_note7", outs_a(), 6'b101110);
    rst_a = 1'b1;
    @(negedge clk);
    check("reset_in_gap", outs_a(), 6'b000000);
    rst_a = 1'b0;
    @(negedge clk);
    check("reset_no_done", outs_a(), 6'b000000);

    // held start replays on the done cycle
    bus_a.start = 1'b1;
    @(negedge clk);
    busy_len(1'b0, len, steps, tone_seen);
    check("held_done_cycle", outs_a(), 6'b010000);
    @(negedge clk);
    check("held_replay", outs_a(), 6'b100000);
    bus_a.start = 1'b0; bus_a.stop = 1'b1;
    @(negedge clk);
    bus_a.stop = 1'b0;

    // random traffic until dut_b is finished
    hold = 1'b0;
    cyc  = 0;
    while (!b_done && cyc < 90000) begin
      if (cyc % 200 == 0) hold = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 999));
      bus_a.stop  = (r < 3);
      rst_a       = (r >= 3 && r < 5);
      bus_a.start = hold ? 1'b1 : ($urandom_range(0, 49) == 0);
      @(negedge clk);
      cyc++;
    end
    bus_a.start = 1'b0; bus_a.stop = 1'b0; rst_a = 1'b0;
    if (!b_done) check("b_timeout", 6'd0, 6'd1);
  endtask

  task automatic run_b();
    rst_b = 1'b1; bus_b.start = 1'b0; bus_b.stop = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    bus_b.start = 1'b1;
    @(negedge clk);                     // t = 0
    bus_b.start = 1'b0;
    check("b_start", outs_b(), 6'b100000);
    repeat (60000) @(negedge clk);      // t = 60000
    check("b_t60000", outs_b(), 6'b100000);
    @(negedge clk);                     // t = 60001
    check("b_rise", outs_b(), 6'b100001);
    repeat (5998) @(negedge clk);       // t = 65999
    check("b_t65999", outs_b(), 6'b100001);
    @(negedge clk);                     // t = 66000
    check("b_gap_silent", outs_b(), 6'b100000);
    repeat (3) @(negedge clk);          // t = 66003
    check("b_gap_end", outs_b(), 6'b100000);
    @(negedge clk);                     // t = 66004
    check("b_note1", outs_b(), 6'b100010);
    bus_b.stop = 1'b1;
    @(negedge clk);
    check("b_stop", outs_b(), 6'b000000);
    bus_b.stop = 1'b0;
    b_done = 1'b1;
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
